// File: rtl/mask_centroid.sv
`default_nettype none
// mask_centroid: per-frame centroid of set mask pixels, serial divide at frame end. Rev 1.0
// Optional build macro CENTROID_CROSSHAIR_EN overlays the previous centroid on out_mark.
module mask_centroid #(
  parameter logic [20:0] MIN_COUNT = 21'd16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       mask,
  input  logic       in_de,
  input  logic       in_vsync,
  input  logic       in_hsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       found,
  output logic       valid,
  output logic       out_mark,
  output logic       out_de,
  output logic       out_vsync,
  output logic       out_hsync
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t state, state_n;

  logic [9:0]  col, row;
  logic [30:0] sum_x, sum_y;
  logic [20:0] cnt;
  logic [30:0] qx, qy;
  logic [20:0] rx, ry;
  logic [20:0] div;
  logic [4:0]  iter;
  logic        found_n;

  logic        frame_end, de_fall, below, mark_n;
  logic [21:0] shx, shy;
  logic [22:0] dfx, dfy;

  assign frame_end = in_vsync & ~out_vsync;
  assign de_fall   = ~in_de & out_de;
  // A zero count must never reach the divider, whatever MIN_COUNT is set to.
  assign below     = (cnt < MIN_COUNT) || (cnt == 21'd0);

  assign shx = {rx, qx[30]};
  assign shy = {ry, qy[30]};
  assign dfx = {1'b0, shx} - {2'b00, div};
  assign dfy = {1'b0, shy} - {2'b00, div};

`ifdef CENTROID_CROSSHAIR_EN
  assign mark_n = mask | (found & in_de & ((col == x) || (row == y)));
`else
  assign mark_n = mask;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (frame_end) state_n = below ? LOAD : DIV;
      DIV:     if (iter == 5'd30) state_n = LOAD;
      LOAD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     state <= IDLE;
    else if (ce) state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_de    <= 1'b0;
      out_vsync <= 1'b0;
      out_hsync <= 1'b0;
      out_mark  <= 1'b0;
      col       <= '0;
      row       <= '0;
      sum_x     <= '0;
      sum_y     <= '0;
      cnt       <= '0;
      qx        <= '0;
      qy        <= '0;
      rx        <= '0;
      ry        <= '0;
      div       <= '0;
      iter      <= '0;
      found_n   <= 1'b0;
      x         <= '0;
      y         <= '0;
      found     <= 1'b0;
      valid     <= 1'b0;
    end else if (ce) begin
      out_de    <= in_de;
      out_vsync <= in_vsync;
      out_hsync <= in_hsync;
      out_mark  <= mark_n;

      if (in_de) begin
        if (col != 10'd1023) col <= col + 10'd1;
      end else if (de_fall) begin
        col <= '0;
      end

      if (frame_end)                     row <= '0;
      else if (de_fall && row != 10'd1023) row <= row + 10'd1;

      if (frame_end) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
      end else if (in_de && mask) begin
        sum_x <= sum_x + {21'd0, col};
        sum_y <= sum_y + {21'd0, row};
        cnt   <= cnt + 21'd1;
      end

      valid <= 1'b0;
      case (state)
        IDLE: begin
          // Snapshots taken outside IDLE are dropped; the accumulators still clear above.
          if (frame_end) begin
            qx      <= sum_x;
            qy      <= sum_y;
            rx      <= '0;
            ry      <= '0;
            div     <= cnt;
            iter    <= '0;
            found_n <= ~below;
          end
        end
        DIV: begin
          rx   <= dfx[22] ? shx[20:0] : dfx[20:0];
          ry   <= dfy[22] ? shy[20:0] : dfy[20:0];
          qx   <= {qx[29:0], ~dfx[22]};
          qy   <= {qy[29:0], ~dfy[22]};
          iter <= iter + 5'd1;
        end
        LOAD: begin
          if (found_n) begin
            x <= qx[9:0];
            y <= qy[9:0];
          end
          found <= found_n;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mask_centroid.sv
`default_nettype none
// Testbench for mask_centroid: random and directed frames against an array-based centroid model.
module tb_mask_centroid;

  localparam logic [20:0] MINC = 21'd16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       mask = 1'b0;
  logic       in_de = 1'b0;
  logic       in_vsync = 1'b0;
  logic       in_hsync = 1'b0;
  logic [9:0] x, y;
  logic       found, valid, out_mark, out_de, out_vsync, out_hsync;

  mask_centroid #(.MIN_COUNT(MINC)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mask(mask),
    .in_de(in_de), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .x(x), .y(y), .found(found), .valid(valid),
    .out_mark(out_mark), .out_de(out_de), .out_vsync(out_vsync), .out_hsync(out_hsync)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference state: expected outputs and the pending centroid result
  int     ce_edges = 0;
  int     valid_due = -100;
  int     cur_x = 0, cur_y = 0, cur_f = 0;
  int     pend_x = 0, pend_y = 0, pend_f = 0;
  longint fr_sx = 0, fr_sy = 0, fr_n = 0;
  logic   e_de = 1'b0, e_vs = 1'b0, e_hs = 1'b0, e_mk = 1'b0;
  bit     mk [0:31][0:31];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("valid", {31'b0, valid}, {31'b0, (ce_edges == valid_due)});
    check("x", {22'b0, x}, cur_x);
    check("y", {22'b0, y}, cur_y);
    check("found", {31'b0, found}, cur_f);
    check("out_de", {31'b0, out_de}, {31'b0, e_de});
    check("out_vsync", {31'b0, out_vsync}, {31'b0, e_vs});
    check("out_hsync", {31'b0, out_hsync}, {31'b0, e_hs});
    check("out_mark", {31'b0, out_mark}, {31'b0, e_mk});
  endtask

  function automatic int gapsel(input int mode, input bit fixed_pt);
    if (mode == 1) return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
    if (mode == 2) return fixed_pt ? 10 : 0;
    return 0;
  endfunction

  // One enabled cycle (optionally preceded by ce-low gap cycles carrying junk inputs)
  task automatic tick(input logic d, input logic v, input logic h, input logic m,
                      input int r, input int c, input int gaps, input logic rs);
    logic mk_exp;
    for (int g = 0; g < gaps; g++) begin
      ce = 1'b0; rst = 1'b0;
      in_de = 1'($urandom); in_vsync = 1'($urandom); in_hsync = 1'($urandom); mask = 1'($urandom);
      @(posedge clk); #1;
      check_outputs();
    end
    ce = rs ? 1'($urandom) : 1'b1;
    rst = rs; in_de = d; in_vsync = v; in_hsync = h; mask = m;
    @(posedge clk); #1;
    if (rs) begin
      e_de = 1'b0; e_vs = 1'b0; e_hs = 1'b0; e_mk = 1'b0;
      cur_x = 0; cur_y = 0; cur_f = 0; valid_due = -100;
      fr_sx = 0; fr_sy = 0; fr_n = 0;
    end else begin
      ce_edges++;
      mk_exp = m;
`ifdef CENTROID_CROSSHAIR_EN
      if (cur_f != 0 && d && (c == cur_x || r == cur_y)) mk_exp = 1'b1;
`endif
      if (v && !e_vs) begin
        if (ce_edges > valid_due) begin
          if (fr_n != 0 && fr_n >= longint'(MINC)) begin
            pend_x = int'((fr_sx / fr_n) % 1024);
            pend_y = int'((fr_sy / fr_n) % 1024);
            pend_f = 1;
            valid_due = ce_edges + 32;
          end else begin
            pend_x = cur_x; pend_y = cur_y; pend_f = 0;
            valid_due = ce_edges + 1;
          end
        end
        fr_sx = 0; fr_sy = 0; fr_n = 0;
      end
      e_de = d; e_vs = v; e_hs = h; e_mk = mk_exp;
      if (ce_edges == valid_due) begin
        cur_x = pend_x; cur_y = pend_y; cur_f = pend_f;
      end
    end
    check_outputs();
  endtask

  // Vsync + blanking, then rows x cols active pixels taken from mk
  task automatic frame(input int rows, input int cols, input int gap_mode,
                       input int rst_at, input bit dbl);
    longint sx = 0, sy = 0, n = 0;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        if (mk[r][c]) begin sx += c; sy += r; n++; end
    for (int i = 0; i < 45; i++) begin
      logic v;
      v = dbl ? (i < 3 || (i >= 6 && i < 9)) : (i < 3);
      tick(1'b0, v, 1'b0, 1'($urandom), 0, 0, gapsel(gap_mode, i == 10), i == rst_at);
    end
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++)
        tick(1'b1, 1'b0, 1'b0, mk[r][c], r, c, gapsel(gap_mode, r == rows / 2 && c == cols / 2), 1'b0);
      for (int h = 0; h < 4; h++)
        tick(1'b0, 1'b0, (h == 1 || h == 2), 1'($urandom), r, 0, gapsel(gap_mode, 1'b0), 1'b0);
    end
    fr_sx = sx; fr_sy = sy; fr_n = n;
  endtask

  task automatic clear_mask();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) mk[r][c] = 1'b0;
  endtask

  task automatic block_mask(input bit drop_corner);
    clear_mask();
    for (int r = 20; r < 24; r++)
      for (int c = 10; c < 14; c++) mk[r][c] = 1'b1;
    if (drop_corner) mk[23][13] = 1'b0;
  endtask

  task automatic random_mask(input int dens);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) mk[r][c] = ($urandom_range(0, 99) < dens);
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 1'b1);

    clear_mask();       frame(24, 16, 0, -1, 1'b0);
    block_mask(1'b0);   frame(24, 16, 0, -1, 1'b0);
    block_mask(1'b1);   frame(24, 16, 0, -1, 1'b0);
    clear_mask();       frame(24, 16, 0, -1, 1'b0);
    block_mask(1'b0);   frame(24, 16, 0, -1, 1'b0);
    block_mask(1'b0);   frame(24, 16, 2, -1, 1'b0);
    block_mask(1'b0);   frame(24, 16, 0, -1, 1'b1);

    for (int k = 0; k < 12; k++) begin
      int dens;
      case ($urandom_range(0, 3))
        0:       dens = 2;
        1:       dens = 5;
        2:       dens = 10;
        default: dens = 50;
      endcase
      random_mask(dens);
      frame(int'($urandom_range(4, 24)), int'($urandom_range(4, 32)),
            (k % 3 == 0) ? 1 : 0, -1, (k % 4 == 1));
    end

    block_mask(1'b0);   frame(24, 16, 0, -1, 1'b0);
    block_mask(1'b0);   frame(24, 16, 0, 15, 1'b0);
    clear_mask();       frame(0, 0, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mask_centroid.md
# mask_centroid

Frame-level centroid extractor for the binary skin mask. Sits directly downstream of the 3x3 opening stage: it consumes `opened` with its `out_de`/`out_vsync`/`out_hsync` and accumulates the coordinate sums and pixel count of set pixels over each frame. At frame end it runs a serial divide and publishes the centroid (x, y) with a one-cycle valid strobe. It re-emits the pixel stream with one cycle of delay for the HDMI output path.

## Interface
- `MIN_COUNT`, default 21'd16: minimum set-pixel count for a frame to report `found`=1.
- `clk`  in  1: pixel clock.
- `rst`  in  1: synchronous, active-high reset.
- `ce`  in  1: clock enable; all state advances only when high.
- `mask`  in  1: opened binary mask pixel.
- `in_de`  in  1: data enable.
- `in_vsync`  in  1: vertical sync, active high.
- `in_hsync`  in  1: horizontal sync.
- `x`  out  10: centroid column.
- `y`  out  10: centroid row.
- `found`  out  1: last reported frame had count ≥ `MIN_COUNT`.
- `valid`  out  1: one-cycle strobe when `x`/`y`/`found` update.
- `out_mark`  out  1: output pixel, mask or overlay.
- `out_de`, `out_vsync`, `out_hsync`  out  1 each: syncs delayed by 1 cycle.

## Operation
- Position counters:
  - `col` increments on each `in_de`=1 cycle and clears on the `in_de` falling edge.
  - `row` increments on each `in_de` falling edge and clears on the `in_vsync` rising edge.
  - Both are 10 bits and saturate at 1023.
- Accumulation: for each cycle with `in_de`=1 and `mask`=1:
  - `sum_x += col`, `sum_y += row` (31 bits each);
  - `cnt += 1` (21 bits).
  - Widths are sized so no overflow is possible.
- Frame end is the `in_vsync` rising edge, detected from a registered copy of `in_vsync`.
- FSM states:
  - IDLE: on frame end, snapshot `sum_x`, `sum_y`, `cnt` into the divider and clear the accumulators in the same cycle. If `cnt` < `MIN_COUNT`, go to LOAD with `found_n`=0. Otherwise go to DIV with `found_n`=1.
  - DIV: restoring shift-subtract divide, one quotient bit per cycle, both axes in parallel, 31 iterations. Then go to LOAD.
  - LOAD: if `found_n`=1, `x`/`y` take the low 10 bits of the quotients (truncating division). If `found_n`=0, `x`/`y` hold their previous values. `found` ← `found_n`. `valid` is pulsed. Return to IDLE.
- A frame-end edge while in DIV or LOAD: the accumulators are still cleared, but that snapshot is discarded and no extra `valid` is produced.
- `cnt`=0 never reaches the divider, so there is no division by zero.
- Pixel path: `out_de`/`out_vsync`/`out_hsync` are the inputs registered once; `out_mark` is the registered `mask` (see Configuration).
- With `ce`=0, every register holds, including the FSM and the divider.
- `rst`=1 at any point, including mid-DIV, returns the block to IDLE with every register cleared. No `valid` is emitted for the aborted frame.

## Timing
- Reset values: `x`=0, `y`=0, `found`=0, `valid`=0, `out_mark`=0, `out_de`=0, `out_vsync`=0, `out_hsync`=0.
- Pixel-path latency is exactly 1 `ce` cycle.
- Frame-end edge sampled in cycle T (IDLE):
  - found path: DIV occupies T+1..T+31, LOAD is at T+32, and `valid`=1 with new `x`/`y`/`found` appears in T+33.
  - below-threshold path: LOAD is at T+1 and `valid` appears in T+2.
- `valid` is high for exactly one `ce`-enabled cycle.
- Cycle counts above are counted in `ce`=1 cycles.

## Configuration
- `CENTROID_CROSSHAIR_EN` defined: `out_mark` = registered (`mask` OR (`found` AND `in_de` AND (`col`==`x` OR `row`==`y`))). This draws the previous frame's centroid as a crosshair on the current frame.
- `CENTROID_CROSSHAIR_EN` undefined: `out_mark` = registered `mask` only. No comparators are built.
- Centroid outputs and timing are identical in both builds.

## Test plan
- Reset: assert `rst` 3 cycles with random inputs → all outputs 0; FSM in IDLE.
- Single pixel: `MIN_COUNT`=1, mask set only at (col 5, row 3), frame end → `valid` at T+33, `x`=5, `y`=3, `found`=1.
- Block: 4x4 set at cols 10..13, rows 20..23, `MIN_COUNT`=16 → `x`=11, `y`=21, `found`=1. The same block with `MIN_COUNT`=17 → `valid` at T+2, `found`=0, `x`/`y` unchanged.
- Empty frame after the block frame → `found`=0, `x`=11, `y`=21 held, exactly one `valid`.
- `ce` gaps: `ce` low for 10 cycles mid-line and during DIV → same `x`/`y` as the gap-free run; `valid` delayed by exactly the gap length.
- Reset at T+15, mid-DIV → no `valid`, `x`=`y`=0. With `CENTROID_CROSSHAIR_EN`, after a frame with `x`=11, `y`=21, `found`=1, a blank next frame → `out_mark`=1 on all of row 21 and column 11, and 0 elsewhere.
